// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller.
// Forwarding mux selects, syscall sequencer states, and the register-match helper.
// Optional build macro used by hazard_ctrl: STALL_STATS_EN.
package mips_ctrl_pkg;

   // Forwarding mux select encodings for the EX-stage operand muxes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Syscall sequencer states
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      WAIT  = 2'd2
   } sc_state_t;

   // Register-field match that never fires on $0 (hard-wired zero register)
   function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator: picks bypass sources for the decode comparator and EX operands.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow the pipeline register fields directly.
module fwd_sel
   import mips_ctrl_pkg::*;
(
   input  logic [4:0] i_rsd,
   input  logic [4:0] i_rtd,
   input  logic [4:0] i_rse,
   input  logic [4:0] i_rte,
   input  logic [4:0] i_writeregm,
   input  logic       i_regwritem,
   input  logic [4:0] i_writeregw,
   input  logic       i_regwritew,
   output logic       o_forwardad,
   output logic       o_forwardbd,
   output logic [1:0] o_forwardae,
   output logic [1:0] o_forwardbe
);

   // EX operand selects: the younger MEM result wins over the older WB result
   always_comb begin
      o_forwardae = FWD_RF;
      o_forwardbe = FWD_RF;
      if (i_regwritem && reg_hit(i_writeregm, i_rse))      o_forwardae = FWD_MEM;
      else if (i_regwritew && reg_hit(i_writeregw, i_rse)) o_forwardae = FWD_WB;
      if (i_regwritem && reg_hit(i_writeregm, i_rte))      o_forwardbe = FWD_MEM;
      else if (i_regwritew && reg_hit(i_writeregw, i_rte)) o_forwardbe = FWD_WB;
   end

   // Decode comparator only bypasses from MEM; WB is covered by the split-cycle register file
   always_comb begin
      o_forwardad = i_regwritem && reg_hit(i_writeregm, i_rsd);
      o_forwardbd = i_regwritem && reg_hit(i_writeregm, i_rtd);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: load-use and branch stalls, forwarding, syscall freeze/drain/handoff.
// Latency: stall and forward outputs are combinational; sequencer state and syscall_req are registered.
// Backpressure: front end held while a hazard or syscall is pending; host releases via syscall_ack.
// Optional build macro STALL_STATS_EN adds load-use and branch stall cycle counters.
module hazard_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsd,
   input  logic [4:0]  rtd,
   input  logic        branchd,
   input  logic [4:0]  rse,
   input  logic [4:0]  rte,
   input  logic [4:0]  writerege,
   input  logic        regwritee,
   input  logic        memtorege,
   input  logic [4:0]  writeregm,
   input  logic        regwritem,
   input  logic        memtoregm,
   input  logic [4:0]  writeregw,
   input  logic        regwritew,
   input  logic        syscalle,
   input  logic        syscall_ack,
   output logic        stallf,
   output logic        stalld,
   output logic        flushe,
   output logic        forwardad,
   output logic        forwardbd,
   output logic [1:0]  forwardae,
   output logic [1:0]  forwardbe,
   output logic        syscall_req,
   output logic [31:0] lw_stall_cnt,
   output logic [31:0] br_stall_cnt
);

   // Drain counter counts down to zero, so DRAIN lasts exactly DRAIN_CYCLES cycles
   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

   sc_state_t  r_state;
   logic [2:0] r_drain_cnt;
   logic       r_syscall_req;

   logic       w_fwd_ad;
   logic       w_fwd_bd;
   logic [1:0] w_fwd_ae;
   logic [1:0] w_fwd_be;
   logic       w_lwstall;
   logic       w_brstall;
   logic       w_hold;

   fwd_sel u_fwd_sel (
      .i_rsd       (rsd),
      .i_rtd       (rtd),
      .i_rse       (rse),
      .i_rte       (rte),
      .i_writeregm (writeregm),
      .i_regwritem (regwritem),
      .i_writeregw (writeregw),
      .i_regwritew (regwritew),
      .o_forwardad (w_fwd_ad),
      .o_forwardbd (w_fwd_bd),
      .o_forwardae (w_fwd_ae),
      .o_forwardbe (w_fwd_be)
   );

   // Hazard detection: load in EX feeding decode, or branch operand not yet available
   always_comb begin
      w_lwstall = memtorege && (reg_hit(rte, rsd) || reg_hit(rte, rtd));
      w_brstall = branchd &&
                  ((regwritee && (reg_hit(writerege, rsd) || reg_hit(writerege, rtd))) ||
                   (memtoregm && (reg_hit(writeregm, rsd) || reg_hit(writeregm, rtd))));
      w_hold    = (r_state != RUN) || w_lwstall || w_brstall || syscalle;
   end

   // Output steering: reset forces a bubble into EX and silences stalls and bypasses
   always_comb begin
      stallf    = !reset && w_hold;
      stalld    = !reset && w_hold;
      flushe    = reset || w_hold;
      forwardad = !reset && w_fwd_ad;
      forwardbd = !reset && w_fwd_bd;
      forwardae = reset ? FWD_RF : w_fwd_ae;
      forwardbe = reset ? FWD_RF : w_fwd_be;
   end

   // Syscall sequencer: freeze on syscall in EX, drain MEM/WB, then request host service
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= RUN;
         r_drain_cnt   <= 3'd0;
         r_syscall_req <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (syscalle) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               if (r_drain_cnt == 3'd0) begin
                  r_state       <= WAIT;
                  r_syscall_req <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 3'd1;
               end
            end
            WAIT: begin
               if (syscall_ack) begin
                  r_state       <= RUN;
                  r_syscall_req <= 1'b0;
               end
            end
            default: begin
               r_state       <= RUN;
               r_drain_cnt   <= 3'd0;
               r_syscall_req <= 1'b0;
            end
         endcase
      end
   end

   assign syscall_req = r_syscall_req;

`ifdef STALL_STATS_EN
   logic [31:0] r_lw_cnt;
   logic [31:0] r_br_cnt;

   // Stall statistics: a combined load-use + branch stall is attributed to load-use only
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lw_cnt <= 32'd0;
         r_br_cnt <= 32'd0;
      end else if (r_state == RUN) begin
         if (w_lwstall)      r_lw_cnt <= r_lw_cnt + 32'd1;
         else if (w_brstall) r_br_cnt <= r_br_cnt + 32'd1;
      end
   end

   assign lw_stall_cnt = r_lw_cnt;
   assign br_stall_cnt = r_br_cnt;
`else
   assign lw_stall_cnt = 32'd0;
   assign br_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic.
// Outputs are compared every cycle at the falling edge against a rule-level model.
// Build with STALL_STATS_EN to also check the stall counters.
module tb_hazard_ctrl;

   localparam int DC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rsd, rtd, rse, rte, writerege, writeregm, writeregw;
   logic        branchd, regwritee, memtorege, regwritem, memtoregm, regwritew;
   logic        syscalle, syscall_ack;
   logic        stallf, stalld, flushe, forwardad, forwardbd, syscall_req;
   logic [1:0]  forwardae, forwardbe;
   logic [31:0] lw_stall_cnt, br_stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: 0 = running, 1 = draining, 2 = waiting on host
   int          m_mode = 0;
   int          m_left = 0;
   logic [31:0] m_lw   = 0;
   logic [31:0] m_br   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
      .clk(clk), .reset(reset),
      .rsd(rsd), .rtd(rtd), .branchd(branchd),
      .rse(rse), .rte(rte), .writerege(writerege), .regwritee(regwritee), .memtorege(memtorege),
      .writeregm(writeregm), .regwritem(regwritem), .memtoregm(memtoregm),
      .writeregw(writeregw), .regwritew(regwritew),
      .syscalle(syscalle), .syscall_ack(syscall_ack),
      .stallf(stallf), .stalld(stalld), .flushe(flushe),
      .forwardad(forwardad), .forwardbd(forwardbd),
      .forwardae(forwardae), .forwardbe(forwardbe),
      .syscall_req(syscall_req),
      .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit same(input logic [4:0] a, input logic [4:0] b);
      return (a != 0) && (a == b);
   endfunction

   function automatic bit m_lwstall();
      return memtorege && (same(rte, rsd) || same(rte, rtd));
   endfunction

   function automatic bit m_brstall();
      bit e_hit, m_hit;
      e_hit = regwritee && (same(writerege, rsd) || same(writerege, rtd));
      m_hit = memtoregm && (same(writeregm, rsd) || same(writeregm, rtd));
      return branchd && (e_hit || m_hit);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (regwritem && same(writeregm, src)) return 2'b10;
      if (regwritew && same(writeregw, src)) return 2'b01;
      return 2'b00;
   endfunction

   // Move to mid-cycle and compare every output against the model
   task automatic settle();
      bit hold;
      #4;
      hold = (m_mode != 0) || m_lwstall() || m_brstall() || syscalle;
      chk("stallf", stallf, reset ? 0 : hold);
      chk("stalld", stalld, reset ? 0 : hold);
      chk("flushe", flushe, reset ? 1 : hold);
      chk("forwardae", forwardae, reset ? 0 : m_fwd(rse));
      chk("forwardbe", forwardbe, reset ? 0 : m_fwd(rte));
      chk("forwardad", forwardad, reset ? 0 : (regwritem && same(writeregm, rsd)));
      chk("forwardbd", forwardbd, reset ? 0 : (regwritem && same(writeregm, rtd)));
      chk("syscall_req", syscall_req, m_mode == 2);
`ifdef STALL_STATS_EN
      chk("lw_stall_cnt", lw_stall_cnt, m_lw);
      chk("br_stall_cnt", br_stall_cnt, m_br);
`else
      chk("lw_stall_cnt", lw_stall_cnt, 0);
      chk("br_stall_cnt", br_stall_cnt, 0);
`endif
   endtask

   // Clock edge: advance the model from the inputs present at the edge
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_mode = 0; m_left = 0; m_lw = 0; m_br = 0;
      end else begin
         if (m_mode == 0) begin
            if (m_lwstall())      m_lw = m_lw + 1;
            else if (m_brstall()) m_br = m_br + 1;
         end
         case (m_mode)
            0: if (syscalle) begin m_mode = 1; m_left = DC; end
            1: begin m_left--; if (m_left == 0) m_mode = 2; end
            default: if (syscall_ack) m_mode = 0;
         endcase
      end
      #1;
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   task automatic clear_inputs();
      rsd = 0; rtd = 0; rse = 0; rte = 0; writerege = 0; writeregm = 0; writeregw = 0;
      branchd = 0; regwritee = 0; memtorege = 0; regwritem = 0; memtoregm = 0; regwritew = 0;
      syscalle = 0; syscall_ack = 0;
   endtask

   initial begin
      int frz;
      clear_inputs();
      reset = 1;
      @(posedge clk); #1;

      // Reset state
      settle();
      chk("rst_flushe", flushe, 1);
      chk("rst_stallf", stallf, 0);
      chk("rst_req", syscall_req, 0);
      tick();
      reset = 0;
      cyc();

      // EX forwarding priority
      regwritem = 1; writeregm = 8; rse = 8; rte = 8; regwritew = 1; writeregw = 8;
      settle(); chk("fae_mem", forwardae, 2'b10); chk("fbe_mem", forwardbe, 2'b10); tick();
      regwritem = 0;
      settle(); chk("fae_wb", forwardae, 2'b01); tick();
      rse = 0; writeregm = 0; writeregw = 0; regwritem = 1;
      settle(); chk("fae_r0", forwardae, 2'b00); tick();
      clear_inputs();

      // Load-use stall lasts one cycle
      reset = 1; cyc(); reset = 0;
      memtorege = 1; rte = 9; rsd = 9;
      settle(); chk("lw_stallf", stallf, 1); chk("lw_flushe", flushe, 1); tick();
      memtorege = 0;
      settle(); chk("lw_release", stallf, 0);
`ifdef STALL_STATS_EN
      chk("lw_cnt_one", lw_stall_cnt, 1);
`endif
      tick();
      clear_inputs();

      // Branch hazard: ALU in EX, then load in MEM, then ALU in MEM forwards
      branchd = 1; regwritee = 1; writerege = 4; rtd = 4;
      settle(); chk("br_ex", stalld, 1); tick();
      regwritee = 0; memtoregm = 1; regwritem = 1; writeregm = 4;
      settle(); chk("br_memload", stalld, 1); tick();
      memtoregm = 0;
      settle(); chk("br_release", stalld, 0); chk("br_fwdbd", forwardbd, 1); tick();
      clear_inputs();

      // Syscall: 1 EX cycle + DC drain cycles + 3 wait cycles, ack on the third
      frz = 0;
      syscalle = 1;
      settle(); if (stallf) frz++; tick();
      syscalle = 0;
      for (int i = 0; i < DC; i++) begin
         settle(); if (stallf) frz++; chk("sc_drain_req", syscall_req, 0); tick();
      end
      for (int i = 0; i < 3; i++) begin
         syscall_ack = (i == 2);
         settle(); if (stallf) frz++; chk("sc_wait_req", syscall_req, 1); tick();
      end
      syscall_ack = 0;
      settle(); chk("sc_req_drop", syscall_req, 0); chk("sc_unfreeze", stallf, 0); tick();
      chk("sc_freeze_len", frz, 6);

      // Reset while waiting on the host
      syscalle = 1; cyc(); syscalle = 0;
      for (int i = 0; i < DC; i++) cyc();
      settle(); chk("rw_req", syscall_req, 1); tick();
      reset = 1; regwritem = 1; writeregm = 8; rse = 8;
      settle(); chk("rw_flushe", flushe, 1); chk("rw_stallf", stallf, 0); chk("rw_fae", forwardae, 0); tick();
      reset = 0; clear_inputs();
      settle(); chk("rw_req_clr", syscall_req, 0); chk("rw_run", stallf, 0); tick();

      // Spurious ack in RUN
      syscall_ack = 1;
      settle(); chk("sp_req", syscall_req, 0); chk("sp_stall", stallf, 0); tick();
      syscall_ack = 0;
      settle(); chk("sp_req2", syscall_req, 0); tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         rsd         = 5'($urandom_range(0, 3));
         rtd         = 5'($urandom_range(0, 3));
         rse         = 5'($urandom_range(0, 3));
         rte         = 5'($urandom_range(0, 3));
         writerege   = 5'($urandom_range(0, 3));
         writeregm   = 5'($urandom_range(0, 3));
         writeregw   = 5'($urandom_range(0, 3));
         branchd     = 1'($urandom_range(0, 1));
         regwritee   = 1'($urandom_range(0, 1));
         memtorege   = 1'($urandom_range(0, 1));
         regwritem   = 1'($urandom_range(0, 1));
         memtoregm   = 1'($urandom_range(0, 1));
         regwritew   = 1'($urandom_range(0, 1));
         syscalle    = ($urandom_range(0, 29) == 0);
         syscall_ack = ($urandom_range(0, 2) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives the decode/execute pipeline register's flush input, the fetch/decode stall enables, and the forwarding mux selects for the decode and execute stages.
- Contains the syscall sequencer FSM: on a syscall in EX it freezes the front end, drains the back end, then hands off to the host with a req/ack handshake.

Parameters:
- DRAIN_CYCLES, 2, cycles to wait after syscall leaves EX so MEM/WB complete; legal range 1..7.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rsd  in  5  rs field in decode
- rtd  in  5  rt field in decode
- branchd  in  1  decode instruction is a branch (compare in decode)
- rse  in  5  rs held in EX register
- rte  in  5  rt held in EX register
- writerege  in  5  destination register in EX (after regdst/jumplink mux)
- regwritee  in  1  EX instruction writes the register file
- memtorege  in  1  EX instruction is a load
- writeregm  in  5  destination register in MEM
- regwritem  in  1  MEM instruction writes the register file
- memtoregm  in  1  MEM instruction is a load
- writeregw  in  5  destination register in WB
- regwritew  in  1  WB instruction writes the register file
- syscalle  in  1  syscall flag held in EX register
- syscall_ack  in  1  host done servicing the syscall
- stallf  out  1  hold the PC
- stalld  out  1  hold the IF/ID register
- flushe  out  1  flush the ID/EX register to a bubble
- forwardad  out  1  decode comparator A takes the MEM ALU result
- forwardbd  out  1  decode comparator B takes the MEM ALU result
- forwardae  out  2  EX operand A select
- forwardbe  out  2  EX operand B select
- syscall_req  out  1  syscall pending for the host
- lw_stall_cnt  out  32  load-use stall cycles (optional feature)
- br_stall_cnt  out  32  branch stall cycles (optional feature)

Behaviour:
- Register 0 is excluded from every comparison; a match on $0 never forwards or stalls.
- forwardae: 2'b10 if regwritem && writeregm==rse; else 2'b01 if regwritew && writeregw==rse; else 2'b00. MEM has priority over WB. forwardbe is the same using rte.
- forwardad = regwritem && writeregm==rsd. forwardbd is the same using rtd.
- lwstall = memtorege && (writerege==rsd || writerege==rte... ) is not used; the rule is lwstall = memtorege && (rte==rsd || rte==rtd).
- brstall = branchd && ((regwritee && writerege∈{rsd,rtd}) || (memtoregm && writeregm∈{rsd,rtd})).
- In RUN: stallf = stalld = flushe = lwstall | brstall | syscalle.
- Forwarding and stall outputs are combinational (0-cycle latency). FSM state is registered.
- FSM states: RUN, DRAIN, WAIT.
  - RUN & syscalle → DRAIN, with drain counter loaded to DRAIN_CYCLES-1.
  - DRAIN: counter decrements each cycle; at 0 → WAIT.
  - WAIT: syscall_req=1; on syscall_ack → RUN the next cycle.
  - In DRAIN and WAIT: stallf = stalld = flushe = 1, regardless of hazards.
- syscall_req is registered and equals (state==WAIT). An ack in the first WAIT cycle is accepted. An ack outside WAIT is ignored.
- Reset (any state, including mid-DRAIN/WAIT): next state RUN, counter 0, syscall_req 0. While reset is high: flushe=1, stallf=stalld=0, all forward selects 0.
- If a load-use hazard and a branch hazard occur together, the stall is a single stall (OR of the two).

Optional Feature:
- STALL_STATS_EN defined:
  - lw_stall_cnt increments each RUN cycle with lwstall=1.
  - br_stall_cnt increments each RUN cycle with brstall=1 and lwstall=0.
  - Both counters are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both counter outputs are tied to 0 and no counter registers exist.

Decomposition:
- Package mips_ctrl_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - FSM state encoding: RUN=2'd0, DRAIN=2'd1, WAIT=2'd2
- Sub-module fwd_sel: purely combinational forwarding comparator producing forwardae/forwardbe/forwardad/forwardbd. Instantiated once; the FSM, stall logic and counters stay in hazard_ctrl.

Test Plan:
- EX→EX forwarding: regwritem=1, writeregm=8, rse=8; regwritew=1, writeregw=8 → forwardae=2'b10. Drop regwritem → 2'b01. Set rse=0 with both writers on $0 → 2'b00.
- Load-use: memtorege=1, rte=9, rsd=9 → stallf=stalld=flushe=1 for exactly 1 cycle. Next cycle memtorege=0 → all three deassert. With STALL_STATS_EN, lw_stall_cnt=1.
- Branch hazard: branchd=1, regwritee=1, writerege=4, rtd=4 → stall. Next cycle memtoregm=1, writeregm=4 → stall held. Then regwritem=1 (ALU result) → no stall and forwardbd=1.
- Syscall: syscalle=1 for one cycle with DRAIN_CYCLES=2 → 2 DRAIN cycles, then syscall_req=1. Ack on the 3rd WAIT cycle → syscall_req=0 and stalls release the next cycle. Total freeze = 1 + 2 + 3 cycles.
- Reset mid-WAIT: assert reset while syscall_req=1 → next cycle syscall_req=0, state RUN. During reset flushe=1 and stallf=0.
- Spurious ack: syscall_ack=1 while in RUN → no state change, no output change.
